// File: rtl/rect_fill.sv
// rect_fill: rectangle-fill engine feeding the VGA adapter pixel-write port.
//
// On a start pulse in IDLE the rectangle (x0, y0, w, h), base colour and
// pattern mode are latched. The rectangle is then scanned column-major
// (x outer, y inner), with one pixel write per accepted cycle.
//
// Ports
//   clk, rst             clock and synchronous active-high reset
//   start                fill request, sampled only in IDLE
//   x0, y0, w, h         rectangle origin and size in pixels
//   mode                 0 solid, 1 column stripes, 2 row stripes, 3 checker
//   colour               base colour
//   plot_ready           adapter accepts the current write this cycle
//   busy                 high while running or signalling completion
//   done                 one-cycle completion pulse
//   vga_x, vga_y,
//   vga_colour, vga_plot pixel write (coordinates/colour are 0 when not plotting)
//
// Every output is a register loaded from the *next* state. That gives a
// first pixel in the cycle right after the start edge, and it makes the
// pixel held by back-pressure identical cycle to cycle.
module rect_fill #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [X_W-1:0]      x0,
   input  logic [Y_W-1:0]      y0,
   input  logic [X_W-1:0]      w,
   input  logic [Y_W-1:0]      h,
   input  logic [1:0]          mode,
   input  logic [COLOUR_W-1:0] colour,
   input  logic                plot_ready,
   output logic                busy,
   output logic                done,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [X_W:0] SCREEN_W_L = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SCREEN_H_L = (Y_W+1)'(SCREEN_H);

   logic [1:0]          state_reg,  state_next;
   logic [X_W-1:0]      x0_reg,     x0_next;
   logic [Y_W-1:0]      y0_reg,     y0_next;
   logic [X_W-1:0]      w_reg,      w_next;
   logic [Y_W-1:0]      h_reg,      h_next;
   logic [1:0]          mode_reg,   mode_next;
   logic [COLOUR_W-1:0] colour_reg, colour_next;
   logic [X_W-1:0]      dx_reg,     dx_next;
   logic [Y_W-1:0]      dy_reg,     dy_next;

   // Output-side values derived from the next state
   logic [X_W:0]        px_next;
   logic [Y_W:0]        py_next;
   logic                on_screen_next;
   logic                plot_next;
   logic                parity_next;
   logic [COLOUR_W-1:0] checker_colour;
   logic [COLOUR_W-1:0] pat_colour_next;

   // Scan sequencing
   always_comb begin
      state_next  = state_reg;
      x0_next     = x0_reg;
      y0_next     = y0_reg;
      w_next      = w_reg;
      h_next      = h_reg;
      mode_next   = mode_reg;
      colour_next = colour_reg;
      dx_next     = dx_reg;
      dy_next     = dy_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               x0_next     = x0;
               y0_next     = y0;
               w_next      = w;
               h_next      = h;
               mode_next   = mode;
               colour_next = colour;
               dx_next     = '0;
               dy_next     = '0;
               state_next  = (w == '0 || h == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            // vga_plot_reg is exactly "current pixel is on screen" while in
            // RUN: a clipped pixel advances unconditionally, a visible one
            // only once the adapter takes it.
            if (!vga_plot || plot_ready) begin
               if (dy_reg != h_reg - Y_W'(1)) begin
                  dy_next = dy_reg + Y_W'(1);
               end else begin
                  dy_next = '0;
                  if (dx_reg == w_reg - X_W'(1)) begin
                     state_next = ST_DONE;
                  end else begin
                     dx_next = dx_reg + X_W'(1);
                  end
               end
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Checker pattern: every bit of the base colour inverted on odd squares
   assign parity_next = dx_next[0] ^ dy_next[0];

   generate
      for (genvar gi = 0; gi < COLOUR_W; gi++) begin : g_checker
         assign checker_colour[gi] = colour_next[gi] ^ parity_next;
      end
   endgenerate

   // Pixel address and colour for the next cycle. Coordinates carry one
   // extra bit so a rectangle hanging off the screen edge never wraps back
   // onto visible pixels.
   always_comb begin
      px_next        = {1'b0, x0_next} + {1'b0, dx_next};
      py_next        = {1'b0, y0_next} + {1'b0, dy_next};
      on_screen_next = (px_next < SCREEN_W_L) && (py_next < SCREEN_H_L);
      plot_next      = (state_next == ST_RUN) && on_screen_next;

      case (mode_next)
         2'd0:    pat_colour_next = colour_next;
         2'd1:    pat_colour_next = colour_next + COLOUR_W'(dx_next);
         2'd2:    pat_colour_next = colour_next + COLOUR_W'(dy_next);
         default: pat_colour_next = checker_colour;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         x0_reg     <= '0;
         y0_reg     <= '0;
         w_reg      <= '0;
         h_reg      <= '0;
         mode_reg   <= '0;
         colour_reg <= '0;
         dx_reg     <= '0;
         dy_reg     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         x0_reg     <= x0_next;
         y0_reg     <= y0_next;
         w_reg      <= w_next;
         h_reg      <= h_next;
         mode_reg   <= mode_next;
         colour_reg <= colour_next;
         dx_reg     <= dx_next;
         dy_reg     <= dy_next;
         busy       <= (state_next != ST_IDLE);
         done       <= (state_next == ST_DONE);
         vga_plot   <= plot_next;
         vga_x      <= plot_next ? px_next[X_W-1:0] : '0;
         vga_y      <= plot_next ? py_next[Y_W-1:0] : '0;
         vga_colour <= plot_next ? pat_colour_next  : '0;
      end
   end

endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: self-checking bench for rect_fill.
// Each fill is checked against a pixel list built directly from the
// rectangle/pattern rules, plus completion timing and idle behaviour.
module tb_rect_fill;

   localparam int SW = 160;
   localparam int SH = 120;
   localparam int CW = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] x0_i = '0;
   logic [6:0] y0_i = '0;
   logic [7:0] w_i = '0;
   logic [6:0] h_i = '0;
   logic [1:0] mode_i = '0;
   logic [2:0] colour_i = '0;
   logic       plot_ready = 1'b1;
   logic       busy, done, vga_plot;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;

   rect_fill dut (
      .clk(clk), .rst(rst), .start(start),
      .x0(x0_i), .y0(y0_i), .w(w_i), .h(h_i), .mode(mode_i), .colour(colour_i),
      .plot_ready(plot_ready), .busy(busy), .done(done),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
   );

   always #10 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   // Pattern colour straight from the mode rules, modulo 2^CW
   function automatic int pattern(input int m, input int c, input int dx, input int dy);
      int mask = (1 << CW) - 1;
      case (m)
         0: return c;
         1: return (c + dx) & mask;
         2: return (c + dy) & mask;
         default: return (((dx ^ dy) & 1) == 0) ? c : (~c & mask);
      endcase
   endfunction

   // rmode: 0 ready tied high, 1 low on odd cycles, 2 random (mostly high)
   // exp_plots/exp_done < 0: take from the model / stall-adjusted formula
   task automatic run_fill(input int x0, input int y0, input int w, input int h,
                           input int m, input int c, input int rmode,
                           input int mid_start, input int exp_plots,
                           input int exp_done, input string tag);
      pix_t q[$];
      pix_t p;
      int   cyc, stalls, plots, errs, done_cyc, budget, extra, model_n;
      // Reference: column-major scan, keep only visible pixels
      for (int dx = 0; dx < w; dx++)
         for (int dy = 0; dy < h; dy++) begin
            p.x = x0 + dx;
            p.y = y0 + dy;
            p.c = pattern(m, c, dx, dy);
            if (p.x < SW && p.y < SH) q.push_back(p);
         end
      model_n = q.size();
      if (exp_plots < 0) exp_plots = model_n;

      x0_i = 8'(x0); y0_i = 7'(y0); w_i = 8'(w); h_i = 7'(h);
      mode_i = 2'(m); colour_i = 3'(c);
      start = 1'b1;
      cyc = 0; stalls = 0; plots = 0; errs = 0; done_cyc = -1;
      budget = w * h * 4 + 20;
      while (done_cyc < 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
         start = (cyc == mid_start);
         if (cyc == 1 || cyc == mid_start) begin
            // latched values must not follow later input changes
            x0_i = 8'($urandom); y0_i = 7'($urandom); w_i = 8'($urandom);
            h_i = 7'($urandom); mode_i = 2'($urandom); colour_i = 3'($urandom);
         end
         case (rmode)
            0: plot_ready = 1'b1;
            1: plot_ready = (cyc % 2 == 0);
            default: plot_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (busy !== 1'b1) errs++;
         if (done === 1'b1) begin
            done_cyc = cyc;
            if (vga_plot !== 1'b0) errs++;
         end else if (vga_plot === 1'b1) begin
            if (q.size() == 0) begin
               errs++;
            end else if (int'(vga_x) != q[0].x || int'(vga_y) != q[0].y ||
                         int'(vga_colour) != q[0].c) begin
               if (errs == 0)
                  $display("  %s: pixel %0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                           tag, plots, vga_x, vga_y, vga_colour, q[0].x, q[0].y, q[0].c);
               errs++;
            end
            if (plot_ready) begin
               plots++;
               if (q.size() != 0) void'(q.pop_front());
            end else begin
               stalls++;
            end
         end else if (vga_x != 0 || vga_y != 0 || vga_colour != 0) begin
            errs++;
         end
      end
      start = 1'b0;
      plot_ready = 1'b1;
      if (exp_done < 0) exp_done = w * h + 1 + stalls;
      chk({tag, " pixel_errors"}, errs, 0);
      chk({tag, " plot_count"}, plots, exp_plots);
      chk({tag, " done_cycle"}, done_cyc, exp_done);
      // back in IDLE the cycle after done; no extra pulses or writes follow
      @(negedge clk);
      chk({tag, " idle_after_done"}, {busy, done, vga_plot}, 0);
      extra = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done || vga_plot || busy) extra++;
      end
      chk({tag, " no_second_fill"}, extra, 0);
      $display("fill %s: x0=%0d y0=%0d w=%0d h=%0d mode=%0d col=%0d plots=%0d stalls=%0d done@%0d",
               tag, x0, y0, w, h, m, c, plots, stalls, done_cyc);
   endtask

   typedef struct {
      string name;
      int x0, y0, w, h, m, c, rmode, mid, exp_plots, exp_done;
   } vec_t;

   initial begin
      vec_t tbl[9];
      int   extra;
      tbl[0] = '{"full_stripes", 0, 0, 160, 120, 1, 0, 0, 0, 19200, 19201};
      tbl[1] = '{"clip_checker", 156, 118, 8, 4, 3, 5, 0, 0, 8, 33};
      tbl[2] = '{"row_stripes", 10, 20, 3, 10, 2, 6, 0, 0, 30, 31};
      tbl[3] = '{"zero_w", 0, 0, 0, 5, 0, 1, 0, 0, 0, 1};
      tbl[4] = '{"zero_h", 4, 4, 3, 0, 1, 2, 0, 0, 0, 1};
      tbl[5] = '{"solid_ready", 0, 0, 2, 2, 0, 3, 0, 0, 4, 5};
      tbl[6] = '{"backpressure", 0, 0, 2, 2, 0, 3, 1, 0, 4, 9};
      tbl[7] = '{"all_clipped", 250, 125, 10, 4, 0, 7, 0, 0, 0, 41};
      tbl[8] = '{"mid_start", 30, 40, 3, 3, 1, 4, 0, 4, 9, 10};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {busy, done, vga_plot, vga_x, vga_y, vga_colour}, 0);

      for (int i = 0; i < 9; i++)
         run_fill(tbl[i].x0, tbl[i].y0, tbl[i].w, tbl[i].h, tbl[i].m, tbl[i].c,
                  tbl[i].rmode, tbl[i].mid, tbl[i].exp_plots, tbl[i].exp_done,
                  tbl[i].name);

      // Reset in the middle of a 10x10 fill
      x0_i = 8'd2; y0_i = 7'd3; w_i = 8'd10; h_i = 7'd10; mode_i = 2'd1; colour_i = 3'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("reset_mid_outputs", {busy, done, vga_plot, vga_x, vga_y, vga_colour}, 0);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy || vga_plot) extra++;
      end
      chk("reset_mid_no_done", extra, 0);
      run_fill(2, 3, 10, 10, 1, 2, 0, 0, -1, 101, "after_reset");

      // Randomised fills near the screen corner with random back-pressure
      for (int i = 0; i < 12; i++)
         run_fill($urandom_range(140, 175), $urandom_range(100, 127),
                  $urandom_range(0, 12), $urandom_range(0, 8),
                  $urandom_range(0, 3), $urandom_range(0, 7), 2, 0, -1, -1,
                  $sformatf("rand%0d", i));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
